// File: rtl/ifu_lsu_mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU memory-port arbiter and its neighbours.
// State and owner encodings are fixed so debug views and counters decode the same way everywhere.
package ifu_lsu_mem_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

endpackage

// File: rtl/ifu_lsu_mem_arbiter_pick.sv
// Combinational winner select between the fetch and load/store requesters.
// A lone requester always wins; on a conflict the mode parameter decides.
module mem_arb_pick
   import ifu_lsu_mem_arbiter_pkg::*;
#(
   parameter int RR_MODE = 0
) (
   input  logic i_ifu_valid,
   input  logic i_lsu_valid,
   input  logic i_last_grant,
   output logic o_grant_ifu,
   output logic o_grant_lsu
);

   logic w_lsu_on_conflict;

   // Round-robin hands a conflict to whichever master was not served last.
   assign w_lsu_on_conflict = (RR_MODE != 0) ? (i_last_grant == OWN_IFU) : 1'b1;

   assign o_grant_lsu = i_lsu_valid & (~i_ifu_valid | w_lsu_on_conflict);
   assign o_grant_ifu = i_ifu_valid & (~i_lsu_valid | ~w_lsu_on_conflict);

endmodule

// File: rtl/ifu_lsu_mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU (read/write), one transaction in flight.
// Handshakes: a transfer happens on a cycle where valid and ready are both high; valid never waits on ready.
module ifu_lsu_mem_arbiter
   import ifu_lsu_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RR_MODE = 0
) (
   input  logic                clock,
   input  logic                reset,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_resp_rdata,
   output logic                ifu_resp_err,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wmask,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_resp_rdata,
   output logic                lsu_resp_err,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_resp_rdata,
   input  logic                mem_resp_err,

   output logic                owner,
   output logic                busy,
   output logic [31:0]         ifu_grant_cnt,
   output logic [31:0]         lsu_grant_cnt,
   output logic [31:0]         conflict_cnt
);

   arb_state_e            r_state;
   arb_state_e            w_next_state;
   owner_e                r_owner;
   owner_e                r_last_grant;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_wen;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_wmask;
   logic [31:0]           r_ifu_grant_cnt;
   logic [31:0]           r_lsu_grant_cnt;
   logic [31:0]           r_conflict_cnt;

   logic                  w_grant_ifu;
   logic                  w_grant_lsu;
   logic                  w_accept;
   logic                  w_conflict;

   mem_arb_pick #(
      .RR_MODE (RR_MODE)
   ) u_pick (
      .i_ifu_valid  (ifu_req_valid),
      .i_lsu_valid  (lsu_req_valid),
      .i_last_grant (r_last_grant),
      .o_grant_ifu  (w_grant_ifu),
      .o_grant_lsu  (w_grant_lsu)
   );

   assign w_accept   = (r_state == IDLE) && !reset && (w_grant_ifu || w_grant_lsu);
   assign w_conflict = (r_state == IDLE) && ifu_req_valid && lsu_req_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Handshake outputs are held low while reset is high so nothing transfers during reset.
   always_comb begin
      w_next_state   = r_state;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      if (!reset) begin
         case (r_state)
            IDLE: begin
               ifu_req_ready = w_grant_ifu;
               lsu_req_ready = w_grant_lsu;
               if (w_grant_ifu || w_grant_lsu) begin
                  w_next_state = REQ;
               end
            end
            REQ: begin
               mem_req_valid = 1'b1;
               if (mem_req_ready) begin
                  w_next_state = RESP;
               end
            end
            RESP: begin
               if (r_owner == OWN_LSU) begin
                  lsu_resp_valid = mem_resp_valid;
                  mem_resp_ready = lsu_resp_ready;
                  if (mem_resp_valid && lsu_resp_ready) begin
                     w_next_state = IDLE;
                  end
               end else begin
                  ifu_resp_valid = mem_resp_valid;
                  mem_resp_ready = ifu_resp_ready;
                  if (mem_resp_valid && ifu_resp_ready) begin
                     w_next_state = IDLE;
                  end
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   // Request fields load only on acceptance, so they stay stable for the whole REQ phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_owner         <= OWN_IFU;
         r_last_grant    <= OWN_IFU;
         r_addr          <= '0;
         r_wen           <= 1'b0;
         r_wdata         <= '0;
         r_wmask         <= '0;
         r_ifu_grant_cnt <= 32'd0;
         r_lsu_grant_cnt <= 32'd0;
         r_conflict_cnt  <= 32'd0;
      end else begin
         if (w_accept) begin
            if (w_grant_lsu) begin
               r_owner         <= OWN_LSU;
               r_last_grant    <= OWN_LSU;
               r_addr          <= lsu_req_addr;
               r_wen           <= lsu_req_wen;
               r_wdata         <= lsu_req_wdata;
               r_wmask         <= lsu_req_wmask;
               r_lsu_grant_cnt <= r_lsu_grant_cnt + 32'd1;
            end else begin
               r_owner         <= OWN_IFU;
               r_last_grant    <= OWN_IFU;
               r_addr          <= ifu_req_addr;
               r_wen           <= 1'b0;
               r_wdata         <= '0;
               r_wmask         <= '0;
               r_ifu_grant_cnt <= r_ifu_grant_cnt + 32'd1;
            end
         end
         if (w_conflict) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
         end
      end
   end

   assign mem_req_addr   = r_addr;
   assign mem_req_wen    = r_wen;
   assign mem_req_wdata  = r_wdata;
   assign mem_req_wmask  = r_wmask;

   assign ifu_resp_rdata = mem_resp_rdata;
   assign ifu_resp_err   = mem_resp_err;
   assign lsu_resp_rdata = mem_resp_rdata;
   assign lsu_resp_err   = mem_resp_err;

   assign owner          = r_owner;
   assign busy           = (r_state != IDLE);
   assign ifu_grant_cnt  = r_ifu_grant_cnt;
   assign lsu_grant_cnt  = r_lsu_grant_cnt;
   assign conflict_cnt   = r_conflict_cnt;

   a_single_req_ready: assert property (@(posedge clock) disable iff (reset)
      !(ifu_req_ready && lsu_req_ready));
   a_req_valid_in_req: assert property (@(posedge clock) disable iff (reset)
      mem_req_valid |-> (r_state == REQ));
   a_resp_ready_in_resp: assert property (@(posedge clock) disable iff (reset)
      mem_resp_ready |-> (r_state == RESP));
   a_req_stable: assert property (@(posedge clock) disable iff (reset)
      (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(mem_req_addr)
         && $stable(mem_req_wen) && $stable(mem_req_wdata) && $stable(mem_req_wmask)));

endmodule

// File: tb/tb_ifu_lsu_mem_arbiter.sv
// Two arbiters side by side: index 0 is fixed priority, index 1 is round-robin.
// A transaction-level model predicts winners, memory-side fields, response routing and counters.
module tb_ifu_lsu_mem_arbiter;

   logic        clock;
   logic        reset;

   logic        ifu_req_valid  [2];
   logic        ifu_req_ready  [2];
   logic [31:0] ifu_req_addr   [2];
   logic        ifu_resp_valid [2];
   logic        ifu_resp_ready [2];
   logic [31:0] ifu_resp_rdata [2];
   logic        ifu_resp_err   [2];
   logic        lsu_req_valid  [2];
   logic        lsu_req_ready  [2];
   logic [31:0] lsu_req_addr   [2];
   logic        lsu_req_wen    [2];
   logic [31:0] lsu_req_wdata  [2];
   logic [3:0]  lsu_req_wmask  [2];
   logic        lsu_resp_valid [2];
   logic        lsu_resp_ready [2];
   logic [31:0] lsu_resp_rdata [2];
   logic        lsu_resp_err   [2];
   logic        mem_req_valid  [2];
   logic        mem_req_ready  [2];
   logic [31:0] mem_req_addr   [2];
   logic        mem_req_wen    [2];
   logic [31:0] mem_req_wdata  [2];
   logic [3:0]  mem_req_wmask  [2];
   logic        mem_resp_valid [2];
   logic        mem_resp_ready [2];
   logic [31:0] mem_resp_rdata [2];
   logic        mem_resp_err   [2];
   logic        owner          [2];
   logic        busy           [2];
   logic [31:0] ifu_grant_cnt  [2];
   logic [31:0] lsu_grant_cnt  [2];
   logic [31:0] conflict_cnt   [2];

   int          checks;
   int          failures;

   logic [31:0] m_ifu_g [2];
   logic [31:0] m_lsu_g [2];
   logic [31:0] m_conf  [2];
   bit          m_last  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ifu_lsu_mem_arbiter #(
         .ADDR_W  (32),
         .DATA_W  (32),
         .RR_MODE (g)
      ) u_dut (
         .clock          (clock),
         .reset          (reset),
         .ifu_req_valid  (ifu_req_valid[g]),
         .ifu_req_ready  (ifu_req_ready[g]),
         .ifu_req_addr   (ifu_req_addr[g]),
         .ifu_resp_valid (ifu_resp_valid[g]),
         .ifu_resp_ready (ifu_resp_ready[g]),
         .ifu_resp_rdata (ifu_resp_rdata[g]),
         .ifu_resp_err   (ifu_resp_err[g]),
         .lsu_req_valid  (lsu_req_valid[g]),
         .lsu_req_ready  (lsu_req_ready[g]),
         .lsu_req_addr   (lsu_req_addr[g]),
         .lsu_req_wen    (lsu_req_wen[g]),
         .lsu_req_wdata  (lsu_req_wdata[g]),
         .lsu_req_wmask  (lsu_req_wmask[g]),
         .lsu_resp_valid (lsu_resp_valid[g]),
         .lsu_resp_ready (lsu_resp_ready[g]),
         .lsu_resp_rdata (lsu_resp_rdata[g]),
         .lsu_resp_err   (lsu_resp_err[g]),
         .mem_req_valid  (mem_req_valid[g]),
         .mem_req_ready  (mem_req_ready[g]),
         .mem_req_addr   (mem_req_addr[g]),
         .mem_req_wen    (mem_req_wen[g]),
         .mem_req_wdata  (mem_req_wdata[g]),
         .mem_req_wmask  (mem_req_wmask[g]),
         .mem_resp_valid (mem_resp_valid[g]),
         .mem_resp_ready (mem_resp_ready[g]),
         .mem_resp_rdata (mem_resp_rdata[g]),
         .mem_resp_err   (mem_resp_err[g]),
         .owner          (owner[g]),
         .busy           (busy[g]),
         .ifu_grant_cnt  (ifu_grant_cnt[g]),
         .lsu_grant_cnt  (lsu_grant_cnt[g]),
         .conflict_cnt   (conflict_cnt[g])
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Lone requester wins; conflicts go to LSU (index 0) or to the master not served last (index 1).
   function automatic bit model_pick_lsu(input int m, input logic iv, input logic lv);
      if (!lv) return 1'b0;
      if (!iv) return 1'b1;
      if (m == 0) return 1'b1;
      return (m_last[m] == 1'b0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ifu_g[k] = 32'd0;
         m_lsu_g[k] = 32'd0;
         m_conf[k]  = 32'd0;
         m_last[k]  = 1'b0;
      end
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         ifu_req_valid[k]  = 1'b0;
         ifu_req_addr[k]   = 32'd0;
         ifu_resp_ready[k] = 1'b0;
         lsu_req_valid[k]  = 1'b0;
         lsu_req_addr[k]   = 32'd0;
         lsu_req_wen[k]    = 1'b0;
         lsu_req_wdata[k]  = 32'd0;
         lsu_req_wmask[k]  = 4'd0;
         lsu_resp_ready[k] = 1'b0;
         mem_req_ready[k]  = 1'b0;
         mem_resp_valid[k] = 1'b0;
         mem_resp_rdata[k] = 32'd0;
         mem_resp_err[k]   = 1'b0;
      end
   endtask

   // Entered just after a falling edge with requests already driven; leaves the arbiter idle.
   task automatic run_txn(input int m, input bit exp_lsu, input int stall, input int rdly,
                          input int bp, input logic [31:0] rdata, input logic err);
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_wen;
      logic [3:0]  e_wmask;
      bit          own_rdy;
      bit          exp_v;
      logic        o_valid;
      logic        n_valid;
      logic [31:0] o_rdata;
      logic        o_err;
      checks++;
      if (busy[m] !== 1'b0 || ifu_req_ready[m] !== !exp_lsu || lsu_req_ready[m] !== exp_lsu) begin
         failures++;
         $display("FAIL grant dut=%0d busy=%b ifu_ready=%b lsu_ready=%b required lsu_win=%b",
                  m, busy[m], ifu_req_ready[m], lsu_req_ready[m], exp_lsu);
      end
      if (ifu_req_valid[m] && lsu_req_valid[m]) m_conf[m] = m_conf[m] + 32'd1;
      if (exp_lsu) begin
         e_addr  = lsu_req_addr[m];
         e_wen   = lsu_req_wen[m];
         e_wdata = lsu_req_wdata[m];
         e_wmask = lsu_req_wmask[m];
         m_lsu_g[m] = m_lsu_g[m] + 32'd1;
      end else begin
         e_addr  = ifu_req_addr[m];
         e_wen   = 1'b0;
         e_wdata = 32'd0;
         e_wmask = 4'd0;
         m_ifu_g[m] = m_ifu_g[m] + 32'd1;
      end
      m_last[m] = exp_lsu;
      @(negedge clock);
      if (exp_lsu) lsu_req_valid[m] = 1'b0;
      else ifu_req_valid[m] = 1'b0;
      for (int i = 0; i <= stall; i++) begin
         mem_req_ready[m]  = (i == stall);
         mem_resp_valid[m] = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (mem_req_valid[m] !== 1'b1 || mem_req_addr[m] !== e_addr || mem_req_wen[m] !== e_wen ||
             mem_req_wmask[m] !== e_wmask || (exp_lsu && mem_req_wdata[m] !== e_wdata)) begin
            failures++;
            $display("FAIL mem_req dut=%0d valid=%b addr=%h wen=%b wdata=%h wmask=%h required addr=%h wen=%b wdata=%h wmask=%h",
                     m, mem_req_valid[m], mem_req_addr[m], mem_req_wen[m], mem_req_wdata[m], mem_req_wmask[m],
                     e_addr, e_wen, e_wdata, e_wmask);
         end
         checks++;
         if (ifu_req_ready[m] !== 1'b0 || lsu_req_ready[m] !== 1'b0 || mem_resp_ready[m] !== 1'b0 ||
             busy[m] !== 1'b1 || owner[m] !== exp_lsu) begin
            failures++;
            $display("FAIL req_phase dut=%0d ifu_ready=%b lsu_ready=%b mem_resp_ready=%b busy=%b owner=%b required 0 0 0 1 %b",
                     m, ifu_req_ready[m], lsu_req_ready[m], mem_resp_ready[m], busy[m], owner[m], exp_lsu);
         end
         @(negedge clock);
      end
      mem_req_ready[m] = 1'b0;
      for (int i = 0; i <= rdly + bp; i++) begin
         own_rdy = (i == rdly + bp);
         exp_v   = (i >= rdly);
         mem_resp_valid[m] = exp_v;
         mem_resp_rdata[m] = exp_v ? rdata : $urandom;
         mem_resp_err[m]   = err;
         if (exp_lsu) begin
            lsu_resp_ready[m] = own_rdy;
            ifu_resp_ready[m] = 1'($urandom_range(0, 1));
         end else begin
            ifu_resp_ready[m] = own_rdy;
            lsu_resp_ready[m] = 1'($urandom_range(0, 1));
         end
         #1;
         o_valid = exp_lsu ? lsu_resp_valid[m] : ifu_resp_valid[m];
         n_valid = exp_lsu ? ifu_resp_valid[m] : lsu_resp_valid[m];
         o_rdata = exp_lsu ? lsu_resp_rdata[m] : ifu_resp_rdata[m];
         o_err   = exp_lsu ? lsu_resp_err[m]   : ifu_resp_err[m];
         checks++;
         if (o_valid !== exp_v || n_valid !== 1'b0 || mem_resp_ready[m] !== own_rdy ||
             mem_req_valid[m] !== 1'b0 || busy[m] !== 1'b1 ||
             (exp_v && (o_rdata !== rdata || o_err !== err))) begin
            failures++;
            $display("FAIL resp dut=%0d owner_valid=%b other_valid=%b mem_resp_ready=%b mem_req_valid=%b busy=%b rdata=%h err=%b required %b 0 %b 0 1 %h %b",
                     m, o_valid, n_valid, mem_resp_ready[m], mem_req_valid[m], busy[m], o_rdata, o_err,
                     exp_v, own_rdy, rdata, err);
         end
         @(negedge clock);
      end
      mem_resp_valid[m] = 1'b0;
      ifu_resp_ready[m] = 1'b0;
      lsu_resp_ready[m] = 1'b0;
      #1;
      checks++;
      if (busy[m] !== 1'b0 || ifu_grant_cnt[m] !== m_ifu_g[m] || lsu_grant_cnt[m] !== m_lsu_g[m] ||
          conflict_cnt[m] !== m_conf[m]) begin
         failures++;
         $display("FAIL counters dut=%0d busy=%b ifu=%0d lsu=%0d conflict=%0d required busy=0 ifu=%0d lsu=%0d conflict=%0d",
                  m, busy[m], ifu_grant_cnt[m], lsu_grant_cnt[m], conflict_cnt[m], m_ifu_g[m], m_lsu_g[m], m_conf[m]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         ifu_req_valid[k]  = 1'b1;
         lsu_req_valid[k]  = 1'b1;
         mem_req_ready[k]  = 1'b1;
         mem_resp_valid[k] = 1'b1;
         ifu_resp_ready[k] = 1'b1;
         lsu_resp_ready[k] = 1'b1;
      end
      repeat (2) @(negedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ifu_req_ready[k] !== 1'b0 || lsu_req_ready[k] !== 1'b0 || mem_req_valid[k] !== 1'b0 ||
             mem_resp_ready[k] !== 1'b0 || ifu_resp_valid[k] !== 1'b0 || lsu_resp_valid[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshakes dut=%0d ifu_rdy=%b lsu_rdy=%b mreq_v=%b mresp_rdy=%b ifu_rv=%b lsu_rv=%b required all 0",
                     k, ifu_req_ready[k], lsu_req_ready[k], mem_req_valid[k], mem_resp_ready[k],
                     ifu_resp_valid[k], lsu_resp_valid[k]);
         end
      end
      clear_inputs();
      reset = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (busy[k] !== 1'b0 || owner[k] !== 1'b0 || ifu_grant_cnt[k] !== 32'd0 || lsu_grant_cnt[k] !== 32'd0 ||
             conflict_cnt[k] !== 32'd0 || mem_req_addr[k] !== 32'd0 || mem_req_wen[k] !== 1'b0 ||
             mem_req_wmask[k] !== 4'd0 || mem_req_valid[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state dut=%0d busy=%b owner=%b cnts=%0d/%0d/%0d addr=%h required all 0",
                     k, busy[k], owner[k], ifu_grant_cnt[k], lsu_grant_cnt[k], conflict_cnt[k], mem_req_addr[k]);
         end
      end
   endtask

   task automatic test_ifu_alone();
      ifu_req_valid[0] = 1'b1;
      ifu_req_addr[0]  = 32'h8000_0000;
      #1;
      run_txn(0, 1'b0, 0, 1, 0, 32'h0000_0413, 1'b0);
      checks++;
      if (ifu_grant_cnt[0] !== 32'd1 || busy[0] !== 1'b0) begin
         failures++;
         $display("FAIL ifu_alone grant_cnt=%0d busy=%b required 1 0", ifu_grant_cnt[0], busy[0]);
      end
   endtask

   task automatic test_fixed_conflict();
      ifu_req_valid[0] = 1'b1;
      ifu_req_addr[0]  = 32'h8000_0004;
      lsu_req_valid[0] = 1'b1;
      lsu_req_addr[0]  = 32'h8000_1000;
      lsu_req_wen[0]   = 1'b0;
      lsu_req_wdata[0] = 32'd0;
      lsu_req_wmask[0] = 4'd0;
      #1;
      run_txn(0, 1'b1, 0, 0, 0, 32'h1111_2222, 1'b0);
      checks++;
      if (conflict_cnt[0] !== 32'd1 || ifu_req_addr[0] !== 32'h8000_0004) begin
         failures++;
         $display("FAIL fixed_conflict conflict_cnt=%0d required 1", conflict_cnt[0]);
      end
      #1;
      run_txn(0, 1'b0, 1, 0, 0, 32'h3333_4444, 1'b0);
   endtask

   task automatic test_rr_conflict();
      lsu_req_valid[1] = 1'b1;
      lsu_req_addr[1]  = 32'h9000_0000;
      lsu_req_wen[1]   = 1'b0;
      #1;
      run_txn(1, 1'b1, 0, 0, 0, 32'h0000_00AA, 1'b0);
      ifu_req_valid[1] = 1'b1;
      ifu_req_addr[1]  = 32'h8000_0004;
      lsu_req_valid[1] = 1'b1;
      lsu_req_addr[1]  = 32'h8000_1000;
      #1;
      run_txn(1, 1'b0, 0, 0, 0, 32'h0000_00BB, 1'b0);
      ifu_req_valid[1] = 1'b1;
      ifu_req_addr[1]  = 32'h8000_0008;
      #1;
      run_txn(1, 1'b1, 0, 0, 0, 32'h0000_00CC, 1'b0);
      #1;
      run_txn(1, 1'b0, 0, 0, 0, 32'h0000_00DD, 1'b0);
      checks++;
      if (conflict_cnt[1] !== 32'd2) begin
         failures++;
         $display("FAIL rr_conflict conflict_cnt=%0d required 2", conflict_cnt[1]);
      end
   endtask

   task automatic test_store_stall();
      lsu_req_valid[0] = 1'b1;
      lsu_req_addr[0]  = 32'h8000_2000;
      lsu_req_wen[0]   = 1'b1;
      lsu_req_wdata[0] = 32'hDEAD_BEEF;
      lsu_req_wmask[0] = 4'hF;
      ifu_req_valid[0] = 1'b1;
      ifu_req_addr[0]  = 32'h8000_000C;
      #1;
      run_txn(0, 1'b1, 5, 1, 0, 32'd0, 1'b0);
      #1;
      run_txn(0, 1'b0, 0, 0, 0, 32'h0000_0013, 1'b0);
   endtask

   task automatic test_resp_backpressure();
      lsu_req_valid[0] = 1'b1;
      lsu_req_addr[0]  = 32'h8000_4000;
      lsu_req_wen[0]   = 1'b0;
      #1;
      run_txn(0, 1'b1, 0, 0, 3, 32'hCAFE_F00D, 1'b1);
   endtask

   task automatic test_random(input int m, input int n);
      for (int t = 0; t < n + 2; t++) begin
         if (t < n) begin
            if (!ifu_req_valid[m] && $urandom_range(0, 1) == 1) begin
               ifu_req_valid[m] = 1'b1;
               ifu_req_addr[m]  = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_valid[m] && ($urandom_range(0, 1) == 1 || !ifu_req_valid[m])) begin
               lsu_req_valid[m] = 1'b1;
               lsu_req_addr[m]  = $urandom;
               lsu_req_wen[m]   = 1'($urandom_range(0, 1));
               lsu_req_wdata[m] = $urandom;
               lsu_req_wmask[m] = 4'($urandom_range(0, 15));
            end
         end
         if (ifu_req_valid[m] || lsu_req_valid[m]) begin
            #1;
            run_txn(m, model_pick_lsu(m, ifu_req_valid[m], lsu_req_valid[m]), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)));
         end
      end
   endtask

   task automatic test_reset_in_resp();
      lsu_req_valid[0] = 1'b1;
      lsu_req_addr[0]  = 32'h8000_3000;
      lsu_req_wen[0]   = 1'b0;
      #1;
      @(negedge clock);
      lsu_req_valid[0] = 1'b0;
      mem_req_ready[0] = 1'b1;
      @(negedge clock);
      mem_req_ready[0]  = 1'b0;
      mem_resp_valid[0] = 1'b1;
      lsu_resp_ready[0] = 1'b0;
      #1;
      checks++;
      if (busy[0] !== 1'b1 || lsu_resp_valid[0] !== 1'b1) begin
         failures++;
         $display("FAIL resp_setup busy=%b lsu_resp_valid=%b required 1 1", busy[0], lsu_resp_valid[0]);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (busy[0] !== 1'b0 || ifu_grant_cnt[0] !== 32'd0 || lsu_grant_cnt[0] !== 32'd0 ||
          conflict_cnt[0] !== 32'd0 || ifu_req_ready[0] !== 1'b0 || lsu_req_ready[0] !== 1'b0 ||
          mem_resp_ready[0] !== 1'b0 || lsu_resp_valid[0] !== 1'b0 || mem_req_valid[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_resp busy=%b cnts=%0d/%0d/%0d mem_resp_ready=%b lsu_resp_valid=%b required 0 0/0/0 0 0",
                  busy[0], ifu_grant_cnt[0], lsu_grant_cnt[0], conflict_cnt[0], mem_resp_ready[0], lsu_resp_valid[0]);
      end
      mem_resp_valid[0] = 1'b0;
      ifu_req_valid[0]  = 1'b1;
      ifu_req_addr[0]   = 32'h8000_0100;
      #1;
      run_txn(0, 1'b0, 0, 0, 0, 32'h0000_0093, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      clear_inputs();
      model_reset();
      test_reset();
      test_ifu_alone();
      test_fixed_conflict();
      test_rr_conflict();
      test_store_stall();
      test_resp_backpressure();
      test_random(0, 40);
      test_random(1, 40);
      test_reset_in_resp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_lsu_mem_arbiter.md
Name: ifu_lsu_mem_arbiter

Overview:
Shares the core's single memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). It runs a 3-state FSM and allows one outstanding transaction at a time. Both sides use valid/ready handshakes on the request and response channels. It sits between IFU/LSU and the memory/bus bridge, and keeps grant and contention counters for the performance report.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
RR_MODE, 0, 0 = fixed priority (LSU wins); 1 = round-robin (the master not granted last time wins)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  arbiter accepts IFU request
ifu_req_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  fetch data valid
ifu_resp_ready  in  1  IFU can take response
ifu_resp_rdata  out  DATA_W  fetch data
ifu_resp_err  out  1  bus error on fetch
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  arbiter accepts LSU request
lsu_req_addr  in  ADDR_W  load/store address
lsu_req_wen  in  1  1 = store
lsu_req_wdata  in  DATA_W  store data
lsu_req_wmask  in  DATA_W/8  byte strobes
lsu_resp_valid  out  1  load data / store ack valid
lsu_resp_ready  in  1  LSU can take response
lsu_resp_rdata  out  DATA_W  load data
lsu_resp_err  out  1  bus error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts
mem_req_addr  out  ADDR_W  registered address
mem_req_wen  out  1  registered write enable
mem_req_wdata  out  DATA_W  registered write data
mem_req_wmask  out  DATA_W/8  registered strobes
mem_resp_valid  in  1  memory response valid
mem_resp_ready  out  1  arbiter takes response
mem_resp_rdata  in  DATA_W  response data
mem_resp_err  in  1  response error
owner  out  1  0 = IFU, 1 = LSU (meaningful when busy)
busy  out  1  state != IDLE
ifu_grant_cnt  out  32  IFU grants since reset
lsu_grant_cnt  out  32  LSU grants since reset
conflict_cnt  out  32  IDLE cycles with both requests valid

Behaviour:
- Reset:
  - state = IDLE, owner = 0, last_grant = IFU.
  - Latched request registers are 0; all counters are 0.
  - All valid/ready outputs are 0.
  - Reset mid-transaction abandons the transaction; the memory side is reset in the same cycle.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - The winner is computed combinationally from the req_valid signals.
  - Fixed mode: LSU beats IFU. RR mode: on conflict, the master not equal to last_grant wins.
  - The winner's req_ready = 1; the loser's req_ready = 0.
  - On handshake, latch addr, wen, wdata and wmask (IFU forces wen = 0, wmask = 0), set owner and last_grant, increment that master's grant counter, and go to REQ.
  - No valid request: stay in IDLE with both readies 0.
- REQ:
  - mem_req_valid = 1, driven from registers, so fields stay stable until accepted.
  - Both req_ready = 0.
  - On mem_req_ready, go to RESP.
- RESP:
  - The owner's resp_valid = mem_resp_valid, rdata and err pass through combinationally, and mem_resp_ready = the owner's resp_ready.
  - On handshake, go to IDLE.
  - The non-owner's resp_valid is 0.
- Latency: request accepted at cycle t, mem_req_valid at t+1 at the earliest, response forwarded in the same cycle it arrives. Minimum turnaround is 3 cycles; the next request can be granted in the cycle after the response handshake.
- Invariants:
  - At most one req_ready is high per cycle; both are 0 outside IDLE.
  - mem_req_valid is high only in REQ.
  - mem_resp_ready is low outside RESP, and responses arriving outside RESP are not consumed.
  - A requester that is not granted keeps its request asserted; the arbiter never drops a pending request.
- conflict_cnt increments in every IDLE cycle where both req_valid are 1.
- All counters wrap modulo 2^32.

Decomposition:
- Shared package holds:
  - the state enum (IDLE = 0, REQ = 1, RESP = 2, 2-bit);
  - the owner encoding (OWN_IFU = 0, OWN_LSU = 1);
  - the ADDR_W/DATA_W defaults used by IFU, LSU and the bridge.
- One sub-module, mem_arb_pick: combinational winner select taking ifu_valid, lsu_valid, last_grant and RR_MODE, and producing grant_ifu and grant_lsu.

Test Plan:
- IFU alone, addr 0x80000000, mem_req_ready = 1 at t+1, resp rdata 0x00000413 at t+3 -> ifu_resp_rdata = 0x00000413, ifu_grant_cnt = 1, busy low at t+4.
- Both valid at the same time in fixed mode (IFU 0x80000004, LSU load 0x80001000) -> LSU granted first, conflict_cnt = 1, IFU served next with its address unchanged.
- Same stimulus with RR_MODE = 1 and last_grant = LSU -> IFU wins; a second conflict then grants LSU.
- LSU store wdata 0xDEADBEEF, wmask 0xF; memory holds mem_req_ready low for 5 cycles -> mem_req fields stay stable, lsu_req_ready stays 0 while in REQ.
- Response backpressure: lsu_resp_ready low for 3 cycles with mem_resp_err = 1 -> mem_resp_ready low, lsu_resp_err = 1 held, ifu_resp_valid = 0 throughout.
- Reset asserted in RESP -> next cycle busy = 0, all counters = 0, all readies = 0.
